// File: rtl/fxp8s_pe_seq.sv
// fxp8s_pe_seq: initiator sequencer that clears one fxp8s_pe, streams (weight, activation) pairs into it,
// and reads back the dot product. Define FXP8S_SEQ_TIMEOUT_EN to build the COLLECT timeout.
module fxp8s_pe_seq #(
   parameter int LEN_W   = 8,
   parameter int MUL_LAT = 1,
   parameter int TMO     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_wt,
   input  logic [7:0]       s_act,
   output logic             pe_rstn,
   output logic             pe_en_in,
   output logic             pe_in_buf,
   output logic [7:0]       pe_in_data,
   output logic             pe_in_done,
   input  logic             pe_en_out,
   output logic             pe_rdy_out,
   input  logic [7:0]       pe_out_data,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_data,
   output logic             res_err
);

   // One wait counter serves DRAIN and, when built, the COLLECT timeout.
   localparam int WAIT_MAX = (MUL_LAT > TMO) ? MUL_LAT : TMO;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLR     = 3'd1,
      S_LOAD    = 3'd2,
      S_WT      = 3'd3,
      S_ACT     = 3'd4,
      S_DRAIN   = 3'd5,
      S_COLLECT = 3'd6,
      S_HOLD    = 3'd7
   } state_t;

   state_t            state_r, state_nx_s;
   logic [LEN_W-1:0]  len_r, cnt_r;
   logic [7:0]        act_r, res_data_r;
   logic [WAIT_W-1:0] wait_r;
   logic              is_last_s, drain_done_s, count_en_s, tmo_take_s;

   logic       s_ready_nx_s, pe_en_in_nx_s, pe_in_buf_nx_s, pe_in_done_nx_s;
   logic       pe_rdy_out_nx_s, busy_nx_s, res_valid_nx_s, pe_clr_nx_s;
   logic [7:0] pe_in_data_nx_s;
   logic       s_ready_r, pe_en_in_r, pe_in_buf_r, pe_in_done_r;
   logic       pe_rdy_out_r, busy_r, res_valid_r, pe_clr_r;
   logic [7:0] pe_in_data_r;

   assign is_last_s    = (cnt_r == (len_r - LEN_W'(1)));
   assign drain_done_s = (wait_r == WAIT_W'(MUL_LAT - 1));

`ifdef FXP8S_SEQ_TIMEOUT_EN
   logic res_err_r;

   assign count_en_s = (state_r == S_DRAIN) || (state_r == S_COLLECT);
   assign tmo_take_s = (state_r == S_COLLECT) && !pe_en_out && (wait_r == WAIT_W'(TMO - 1));

   // Error flag: cleared when a new dot product starts, set when COLLECT gives up
   always_ff @(posedge clk) begin
      if (rst) begin
         res_err_r <= 1'b0;
      end else if ((state_r == S_IDLE) && start) begin
         res_err_r <= 1'b0;
      end else if (tmo_take_s) begin
         res_err_r <= 1'b1;
      end
   end

   assign res_err = res_err_r;
`else
   assign count_en_s = (state_r == S_DRAIN);
   assign tmo_take_s = 1'b0;
   assign res_err    = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               if (len != {LEN_W{1'b0}}) state_nx_s = S_CLR;
               else                      state_nx_s = S_HOLD;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_CLR:  state_nx_s = S_LOAD;
         S_LOAD: begin
            if (s_valid) state_nx_s = S_WT;
            else         state_nx_s = S_LOAD;
         end
         S_WT:   state_nx_s = S_ACT;
         S_ACT: begin
            if (is_last_s) state_nx_s = S_DRAIN;
            else           state_nx_s = S_LOAD;
         end
         S_DRAIN: begin
            if (drain_done_s) state_nx_s = S_COLLECT;
            else              state_nx_s = S_DRAIN;
         end
         S_COLLECT: begin
            if (pe_en_out || tmo_take_s) state_nx_s = S_HOLD;
            else                         state_nx_s = S_COLLECT;
         end
         S_HOLD: begin
            if (res_ready) state_nx_s = S_IDLE;
            else           state_nx_s = S_HOLD;
         end
         default: state_nx_s = S_IDLE;
      endcase
   end

   // Output decode from the next state so every PE/stream output leaves a flop
   always_comb begin
      s_ready_nx_s    = 1'b0;
      pe_en_in_nx_s   = 1'b0;
      pe_in_buf_nx_s  = 1'b0;
      pe_in_data_nx_s = 8'h00;
      pe_in_done_nx_s = 1'b0;
      pe_rdy_out_nx_s = 1'b0;
      res_valid_nx_s  = 1'b0;
      pe_clr_nx_s     = 1'b0;
      busy_nx_s       = (state_nx_s != S_IDLE);
      case (state_nx_s)
         S_CLR:  pe_clr_nx_s  = 1'b1;
         S_LOAD: s_ready_nx_s = 1'b1;
         S_WT: begin
            // WT is only entered from a LOAD handshake, so s_wt is the weight being accepted
            pe_en_in_nx_s   = 1'b1;
            pe_in_buf_nx_s  = 1'b1;
            pe_in_data_nx_s = s_wt;
         end
         S_ACT: begin
            pe_en_in_nx_s   = 1'b1;
            pe_in_data_nx_s = act_r;
            pe_in_done_nx_s = is_last_s;
         end
         S_COLLECT: pe_rdy_out_nx_s = 1'b1;
         S_HOLD: begin
            res_valid_nx_s = 1'b1;
            pe_clr_nx_s    = tmo_take_s;
         end
         default: busy_nx_s = (state_nx_s != S_IDLE);
      endcase
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         s_ready_r    <= 1'b0;
         pe_en_in_r   <= 1'b0;
         pe_in_buf_r  <= 1'b0;
         pe_in_data_r <= 8'h00;
         pe_in_done_r <= 1'b0;
         pe_rdy_out_r <= 1'b0;
         busy_r       <= 1'b0;
         res_valid_r  <= 1'b0;
         pe_clr_r     <= 1'b0;
      end else begin
         s_ready_r    <= s_ready_nx_s;
         pe_en_in_r   <= pe_en_in_nx_s;
         pe_in_buf_r  <= pe_in_buf_nx_s;
         pe_in_data_r <= pe_in_data_nx_s;
         pe_in_done_r <= pe_in_done_nx_s;
         pe_rdy_out_r <= pe_rdy_out_nx_s;
         busy_r       <= busy_nx_s;
         res_valid_r  <= res_valid_nx_s;
         pe_clr_r     <= pe_clr_nx_s;
      end
   end

   // Operand, pair counter and result datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         len_r      <= {LEN_W{1'b0}};
         cnt_r      <= {LEN_W{1'b0}};
         act_r      <= 8'h00;
         res_data_r <= 8'h00;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  len_r      <= len;
                  cnt_r      <= {LEN_W{1'b0}};
                  res_data_r <= 8'h00;
               end
            end
            S_LOAD: begin
               if (s_valid) act_r <= s_act;
            end
            S_ACT: begin
               if (!is_last_s) cnt_r <= cnt_r + LEN_W'(1);
            end
            S_COLLECT: begin
               if (pe_en_out)       res_data_r <= pe_out_data;
               else if (tmo_take_s) res_data_r <= 8'h00;
            end
            default: act_r <= act_r;
         endcase
      end
   end

   // Wait counter restarts on every state change
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_r <= {WAIT_W{1'b0}};
      end else if (state_nx_s != state_r) begin
         wait_r <= {WAIT_W{1'b0}};
      end else if (count_en_s) begin
         wait_r <= wait_r + WAIT_W'(1);
      end
   end

   assign s_ready    = s_ready_r;
   assign pe_en_in   = pe_en_in_r;
   assign pe_in_buf  = pe_in_buf_r;
   assign pe_in_data = pe_in_data_r;
   assign pe_in_done = pe_in_done_r;
   assign pe_rdy_out = pe_rdy_out_r;
   assign busy       = busy_r;
   assign res_valid  = res_valid_r;
   assign res_data   = res_data_r;
   // The PE is held in clear throughout rst, not just after the first edge.
   assign pe_rstn    = ~rst & ~pe_clr_r;

endmodule

// File: tb/tb_fxp8s_pe_seq.sv
// Scoreboard bench for fxp8s_pe_seq: a behavioural fxp8s_pe responder, randomized operand streams,
// and an expected-result queue popped by an independent output monitor.
`timescale 1ns/1ps
module tb_fxp8s_pe_seq;
   localparam int LEN_W = 8, MUL_LAT = 1, TMO = 16;

   logic clk = 1'b0;
   logic rst, start, s_valid, s_ready, pe_rstn, pe_en_in, pe_in_buf, pe_in_done;
   logic pe_en_out, pe_rdy_out, busy, res_valid, res_ready, res_err;
   logic [LEN_W-1:0] len;
   logic [7:0] s_wt, s_act, pe_in_data, pe_out_data, res_data;

   fxp8s_pe_seq #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT), .TMO(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .s_valid(s_valid), .s_ready(s_ready), .s_wt(s_wt), .s_act(s_act),
      .pe_rstn(pe_rstn), .pe_en_in(pe_en_in), .pe_in_buf(pe_in_buf), .pe_in_data(pe_in_data),
      .pe_in_done(pe_in_done), .pe_en_out(pe_en_out), .pe_rdy_out(pe_rdy_out),
      .pe_out_data(pe_out_data), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_err(res_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [7:0] data; logic err; int len; } exp_t;
   exp_t sb_q[$];
   logic [7:0] dw[$], da[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: sum of Q4.3 products, each floored to 1/8, wrapped to 8 bits
   function automatic logic [7:0] ref_dot(input logic [7:0] w[$], input logic [7:0] a[$]);
      int sum = 0;
      int p, fl;
      foreach (w[i]) begin
         p  = int'($signed(w[i])) * int'($signed(a[i]));
         fl = p / 8;
         if (p < 0 && (p % 8) != 0) fl = fl - 1;
         sum += fl;
      end
      return sum[7:0];
   endfunction

   // Behavioural fxp8s_pe: weight buffer, MAC accumulator, en_out after in_done
   logic [7:0] pe_wbuf, pe_acc;
   logic pe_pend, pe_eo;
   int pe_dly, pe_delay_cfg;
   bit pe_stuck;
   logic [31:0] pe_p;
   assign pe_en_out   = pe_eo;
   assign pe_out_data = pe_eo ? pe_acc : 8'hA5;
   always @(posedge clk) begin
      if (!pe_rstn) begin
         pe_wbuf <= 8'h00; pe_acc <= 8'h00; pe_pend <= 1'b0; pe_eo <= 1'b0; pe_dly <= 0;
      end else begin
         if (pe_en_in && pe_in_buf) pe_wbuf <= pe_in_data;
         if (pe_en_in && !pe_in_buf) begin
            pe_p = 32'($signed(int'($signed(pe_wbuf)) * int'($signed(pe_in_data))) >>> 3);
            pe_acc <= pe_acc + pe_p[7:0];
            if (pe_in_done) begin pe_pend <= 1'b1; pe_dly <= pe_delay_cfg; end
         end
         if (pe_eo && pe_rdy_out) begin
            pe_eo <= 1'b0; pe_pend <= 1'b0;
         end else if (pe_pend && !pe_eo && !pe_stuck) begin
            if (pe_dly == 0) pe_eo <= 1'b1;
            else             pe_dly <= pe_dly - 1;
         end
      end
   end

   // Monitor: PE-side protocol bookkeeping and result scoreboard
   int mon_acts = 0, mon_dones = 0, mon_done_pos = 0;
   logic held_prev = 1'b0;
   logic [7:0] held_data = 8'h00;
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst) begin
         mon_acts = 0; mon_dones = 0; mon_done_pos = 0; held_prev = 1'b0;
      end else begin
         if (pe_en_in && !pe_in_buf) begin
            mon_acts++;
            if (pe_in_done) begin mon_dones++; mon_done_pos = mon_acts; end
         end
         if (!pe_en_in) chk("pe_idle_inputs", 32'({pe_in_done, pe_in_data}), 32'd0);
         if (res_valid && held_prev) chk("res_data_stable", 32'(res_data), 32'(held_data));
         if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_result: got res_data 0x%0h, required no result", res_data);
            end else begin
               e = sb_q.pop_front();
               chk("res_data", 32'(res_data), 32'(e.data));
               chk("res_err", 32'(res_err), 32'(e.err));
               chk("pe_act_count", 32'(mon_acts), 32'(e.len));
               chk("pe_done_count", 32'(mon_dones), 32'(e.len != 0));
               chk("pe_done_position", 32'(mon_done_pos), 32'(e.len));
            end
            mon_acts = 0; mon_dones = 0; mon_done_pos = 0;
         end
         held_prev = res_valid && !res_ready;
         held_data = res_data;
      end
   end

   task automatic send_pair(input logic [7:0] w, input logic [7:0] a);
      bit ok = 1'b0;
      s_wt = w; s_act = a; s_valid = 1'b1;
      for (int k = 0; k < 200 && !ok; k++) begin @(negedge clk); ok = s_ready; end
      if (!ok) begin n_chk++; n_fail++; $display("FAIL s_ready_wait: got s_ready=0, required 1"); end
      @(posedge clk); #1;
   endtask

   task automatic run_txn(input int L, input bit fast, input int gapmax, input int hold, input bit start_at_exit);
      logic [7:0] w[$], a[$];
      exp_t e;
      int t0;
      bit ok = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < L; i++) begin
         w.push_back((i < dw.size()) ? dw[i] : 8'($urandom_range(255, 0)));
         a.push_back((i < da.size()) ? da[i] : 8'($urandom_range(255, 0)));
      end
      dw.delete(); da.delete();
      e.data = pe_stuck ? 8'h00 : ref_dot(w, a);
      e.err  = pe_stuck;
      e.len  = L;
      sb_q.push_back(e);
      start = 1'b1; len = 8'(L);
      @(negedge clk); t0 = cyc;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < L; i++) begin
         if (!fast) begin
            s_valid = 1'b0;
            repeat ($urandom_range(gapmax, 0)) begin @(posedge clk); #1; end
         end
         send_pair(w[i], a[i]);
         if (!fast) s_valid = 1'b0;
         @(negedge clk);
         chk("wt_phase", 32'({pe_en_in, pe_in_buf, pe_in_data}), 32'({2'b11, w[i]}));
         @(negedge clk);
         chk("act_phase", 32'({pe_en_in, pe_in_buf, pe_in_data, pe_in_done}),
             32'({2'b10, a[i], (i == L - 1)}));
      end
      s_valid = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin @(negedge clk); ok = res_valid; end
      if (!ok) begin
         n_chk++; n_fail++; $display("FAIL res_valid_wait: got res_valid=0, required 1");
         sb_q.delete();
      end else if (L == 0) begin
         chk("len0_within_2", 32'((cyc - t0) <= 2), 32'd1);
      end else if (pe_stuck) begin
         chk("timeout_latency", 32'(cyc - t0), 32'(L * 3 + MUL_LAT + 2 + TMO));
      end else if (fast && pe_delay_cfg == 0) begin
         chk("latency", 32'(cyc - t0), 32'(L * 3 + MUL_LAT + 3));
      end
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      res_ready = 1'b1;
      if (start_at_exit) begin start = 1'b1; len = 8'd3; end
      @(posedge clk); #1;
      res_ready = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("idle_after_hold", 32'({busy, res_valid}), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_wt = 8'h00; s_act = 8'h00;
      res_ready = 1'b0; pe_delay_cfg = 0; pe_stuck = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", 32'({s_ready, pe_en_in, pe_in_buf, pe_in_done, pe_rdy_out, busy, res_valid, res_err, pe_rstn}), 32'd0);
      chk("reset_data", 32'({pe_in_data, res_data}), 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("idle_pe_rstn", 32'({pe_rstn, busy}), 32'b10);

      dw = {8'h08}; da = {8'h10};
      run_txn(1, 1'b1, 0, 0, 1'b0);
      dw = {8'h08, 8'hF8}; da = {8'h08, 8'h10};
      run_txn(2, 1'b1, 0, 0, 1'b0);
      run_txn(0, 1'b1, 0, 1, 1'b0);
      run_txn(3, 1'b0, 1, 5, 1'b0);

      // Abort during ACT of pair 2 of 4, then a clean single-pair run
      @(posedge clk); #1;
      start = 1'b1; len = 8'd4;
      sb_q.push_back('{data: 8'h00, err: 1'b0, len: 4});
      @(posedge clk); #1; start = 1'b0;
      send_pair(8'h11, 8'h22);
      send_pair(8'h33, 8'h44);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      chk("abort_pe_rstn", 32'(pe_rstn), 32'd0);
      @(posedge clk); #1; rst = 1'b0; s_valid = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("abort_idle", 32'({busy, s_ready, res_valid, pe_en_in}), 32'd0);
      dw = {8'h08}; da = {8'h08};
      run_txn(1, 1'b1, 0, 0, 1'b0);

      run_txn(2, 1'b1, 0, 1, 1'b1);

      for (int t = 0; t < 25; t++) begin
         pe_delay_cfg = $urandom_range(3, 0);
         run_txn(($urandom_range(9, 0) == 0) ? int'($urandom_range(40, 7)) : int'($urandom_range(6, 0)),
                 1'($urandom_range(1, 0)), 2, $urandom_range(3, 0), 1'b0);
      end
      pe_delay_cfg = 0;

`ifdef FXP8S_SEQ_TIMEOUT_EN
      pe_stuck = 1'b1;
      run_txn(1, 1'b1, 0, 0, 1'b0);
      pe_stuck = 1'b0;
      run_txn(2, 1'b1, 0, 0, 1'b0);
`endif

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
